delay_scheduler: RTL and testbench

DELAY_SCHEDULER -- requirements
Module: delay_scheduler

---
 rtl/delay_scheduler.sv | 116 +++++++++++
 tb/tb_delay_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_scheduler.sv
// Round-robin arbiter handing one shared flexcounter to NREQ delay requesters.
// Optional DELAY_SCHED_CANCEL_EN: owner dropping req during RUN aborts its job.
module delay_scheduler #(
  parameter int NREQ       = 4,
  parameter int COUNTWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*COUNTWIDTH-1:0] delay,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic                       busy,
  output logic                       cnt_en,
  output logic [COUNTWIDTH-1:0]      cnt_max,
  input  logic                       cnt_strobe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         owner, owner_nx;
  logic [IW-1:0]         last, last_nx;
  logic [IW-1:0]         win;
  logic                  win_ok;
  logic [COUNTWIDTH-1:0] lat, lat_nx;
  logic [COUNTWIDTH-1:0] win_delay;

  // first pending requester strictly after the previous owner
  always_comb begin
    int idx;
    idx    = 0;
    win    = '0;
    win_ok = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_ok && req[IW'(idx)]) begin
        win    = IW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    win_delay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_delay = delay[i*COUNTWIDTH +: COUNTWIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    lat_nx   = lat;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          state_nx = RUN;
          owner_nx = win;
          lat_nx   = win_delay;
        end
      end
      RUN: begin
`ifdef DELAY_SCHED_CANCEL_EN
        if (!req[owner]) begin
          state_nx = IDLE;
          last_nx  = owner;
        end else if (cnt_strobe) begin
          state_nx = DONE;
        end
`else
        if (cnt_strobe) state_nx = DONE;
`endif
      end
      DONE: begin
        state_nx = IDLE;
        last_nx  = owner;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      lat   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      lat   <= lat_nx;
    end
  end

  always_comb begin
    grant   = '0;
    done    = '0;
    busy    = (state != IDLE);
    cnt_en  = (state == RUN);
    cnt_max = '0;
    if (state != IDLE) grant = NREQ'(1) << owner;
    if (state == DONE) done = NREQ'(1) << owner;
    if (state == RUN) cnt_max = lat;
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: directed table, corner sequences, random vs model.
// Honours DELAY_SCHED_CANCEL_EN when the design is built with it.
module tb_delay_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [31:0]     delay;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic            cnt_en;
  logic [CW-1:0]   cnt_max;
  logic            cnt_strobe;

  int errors = 0;
  int checks = 0;

  delay_scheduler #(.NREQ(NREQ), .COUNTWIDTH(CW)) dut (
    .clk        (clk),
    .RST        (rst),
    .req        (req),
    .delay      (delay),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .cnt_en     (cnt_en),
    .cnt_max    (cnt_max),
    .cnt_strobe (cnt_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared flexcounter: clears while disabled, strobes at count >= max
  int cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (cnt_en) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign cnt_strobe = cnt_en && (cnt >= int'(cnt_max));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: each job is a time window [s, s+d+1] with done in its last cycle
  int kc = 0;
  int m_s = 0, m_d = 0, m_end = -1, m_w = 0, m_last = NREQ - 1;
  bit m_act = 0, m_can = 0;

  function automatic bit rq(input int i);
    logic [1:0] ix;
    ix = 2'(i);
    return req[ix];
  endfunction

  task automatic mdl_step();
    int g, dn, en, mx, bz, exp_v, act_v, pick;
    kc++;
    if (rst) begin
      m_act  = 0;
      m_last = NREQ - 1;
    end else begin
`ifdef DELAY_SCHED_CANCEL_EN
      if (m_act && !m_can && kc - 1 >= m_s && kc - 1 <= m_s + m_d && !rq(m_w)) begin
        m_can = 1;
        m_end = kc - 1;
      end
`endif
      if (!m_act || kc - 1 > m_end) begin
        if (m_act) m_last = m_w;
        m_act = 0;
        pick  = -1;
        for (int i = 1; i <= NREQ; i++)
          if (pick < 0 && rq((m_last + i) % NREQ)) pick = (m_last + i) % NREQ;
        if (pick >= 0) begin
          m_act = 1;
          m_can = 0;
          m_w   = pick;
          m_s   = kc;
          m_d   = int'((delay >> (CW * m_w)) & 32'hFF);
          m_end = m_s + m_d + 1;
        end
      end
    end
    g  = (m_act && kc >= m_s && kc <= m_end) ? (1 << m_w) : 0;
    dn = (g != 0 && !m_can && kc == m_s + m_d + 1) ? g : 0;
    en = (g != 0 && kc <= m_s + m_d) ? 1 : 0;
    mx = (en != 0) ? m_d : 0;
    bz = (g != 0) ? 1 : 0;
    exp_v = (g << 14) | (dn << 10) | (bz << 9) | (en << 8) | mx;
    act_v = int'({grant, done, busy, cnt_en, cnt_max});
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model cyc %0d: got %05h expected %05h", kc, act_v, exp_v);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mdl_step();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n   = 0;
    req = '0;
    while (busy && n < 400) begin
      cyc();
      n++;
    end
    cyc();
  endtask

  task automatic run_job(input string nm, input logic [3:0] r, input logic [31:0] dv,
                         input logic [3:0] eg, input int lat);
    int n, ens;
    req   = r;
    delay = dv;
    cyc();
    n   = 1;
    ens = int'(cnt_en);
    chk({nm, ":grant"}, int'(grant), int'(eg));
    while (done == 0 && n < lat + 4) begin
      cyc();
      n++;
      ens += int'(cnt_en);
    end
    chk({nm, ":lat"}, n, lat);
    chk({nm, ":done"}, int'(done), int'(eg));
    chk({nm, ":en_cycles"}, ens, lat - 1);
    req = '0;
    cyc();
    chk({nm, ":busy"}, int'(busy), 0);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  r;
    logic [31:0] dv;
    logic [3:0]  eg;
    int          lat;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] ons[$];
  int         dcy[$];
  logic [3:0] pg;
  logic [3:0] exp_o[5];
  int         exp_d[5];

  initial begin
    tbl[0] = '{"single_d5",   4'b0001, 32'h0000_0005, 4'b0001, 7};
    tbl[1] = '{"rr_from1",    4'b0110, 32'h0009_0300, 4'b0010, 5};
    tbl[2] = '{"rr_next2",    4'b0110, 32'h0009_0300, 4'b0100, 11};
    tbl[3] = '{"rr_wrap3_d0", 4'b1001, 32'h0000_0001, 4'b1000, 2};
    tbl[4] = '{"max_delay",   4'b0001, 32'h0000_00FF, 4'b0001, 257};
    tbl[5] = '{"all_req",     4'b1111, 32'h0202_0202, 4'b0010, 4};
    tbl[6] = '{"d0_req0",     4'b0001, 32'h0000_0000, 4'b0001, 2};
    tbl[7] = '{"skip_to2",    4'b1100, 32'h0701_0000, 4'b0100, 3};

    rst   = 1'b1;
    req   = '0;
    delay = '0;
    cyc();
    chk("reset_outputs", int'({grant, done, busy, cnt_en, cnt_max}), 0);
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].nm, tbl[i].r, tbl[i].dv, tbl[i].eg, tbl[i].lat);
      cyc();
    end

    // all requesters held with zero delay: strict rotation, 3-cycle jobs
    do_reset();
    exp_o = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{2, 5, 8, 11, 14};
    ons.delete();
    dcy.delete();
    pg    = '0;
    req   = 4'b1111;
    delay = '0;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (grant != 0 && pg == 0) ons.push_back(grant);
      if (done != 0) dcy.push_back(n);
      pg = grant;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rot_grant%0d", i), (i < ons.size()) ? int'(ons[i]) : -1, int'(exp_o[i]));
      chk($sformatf("rot_done%0d", i), (i < dcy.size()) ? dcy[i] : -1, exp_d[i]);
    end
    idle_wait();

    // req2 arrives mid-job: served before req0 is served again
    do_reset();
    ons.delete();
    pg    = '0;
    req   = 4'b0001;
    delay = 32'h0001_0004;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (n == 2) req = 4'b0101;
      if (grant != 0 && pg == 0) ons.push_back(grant);
      pg = grant;
    end
    chk("late_req_g0", (ons.size() > 0) ? int'(ons[0]) : -1, 1);
    chk("late_req_g1", (ons.size() > 1) ? int'(ons[1]) : -1, 4);
    chk("late_req_g2", (ons.size() > 2) ? int'(ons[2]) : -1, 1);
    idle_wait();

    // delay input changes during RUN are ignored
    do_reset();
    req   = 4'b0010;
    delay = 32'h0000_0300;
    cyc();
    delay = 32'h0000_6400;
    chk("latch_max1", int'(cnt_max), 3);
    for (int n = 2; n <= 4; n++) begin
      cyc();
      chk($sformatf("latch_max%0d", n), int'(cnt_max), 3);
    end
    cyc();
    chk("latch_done", int'(done), 2);
    idle_wait();

    // reset aborts a running job at once
    do_reset();
    req   = 4'b0001;
    delay = 32'h0000_000A;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_abort", int'({grant, done, busy, cnt_en, cnt_max}), 0);
    cyc();
    rst = 1'b0;
    run_job("after_rst", 4'b1000, 32'h0100_0000, 4'b1000, 3);
    idle_wait();

`ifdef DELAY_SCHED_CANCEL_EN
    do_reset();
    req   = 4'b0011;
    delay = 32'h0000_020A;
    cyc();
    chk("cancel_g0", int'(grant), 1);
    cyc();
    req = 4'b0010;
    cyc();
    chk("cancel_idle", int'({grant, done, cnt_en}), 0);
    cyc();
    chk("cancel_next", int'(grant), 2);
    begin
      int n;
      n = 4;
      while (done == 0 && n < 12) begin
        cyc();
        n++;
      end
      chk("cancel_next_done", n, 7);
    end
    idle_wait();
`endif

    // random traffic checked cycle by cycle against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        for (int f = 0; f < NREQ; f++) begin
          if ($urandom_range(0, 49) == 0) delay[f*CW +: CW] = 8'($urandom_range(0, 40));
          else delay[f*CW +: CW] = 8'($urandom_range(0, 5));
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    idle_wait();
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
